// File: rtl/imem_axi_responder.sv
// Read-only instruction memory on an AXI4-Lite-style AR/R channel with in-order queue.
// Optional IMEM_RANGE_CHECK_EN: out-of-range fetches return SLVERR with a NOP word.
module imem_axi_responder #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1,
   parameter int QDEPTH      = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_W-1:0]              araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [31:0]                    rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [PW-1:0] P_LAST   = PW'(QDEPTH - 1);
   localparam logic [CW-1:0] Q_FULL   = CW'(QDEPTH);
   localparam logic [2:0]    LAT_INIT = 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [IW-1:0] q_idx_q [QDEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    lat_q, lat_d;
   state_e        state_q, state_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rst_q;

   logic          push;
   logic          pop;
   logic [IW-1:0] ar_idx;
   logic [31:0]   head_data;
   logic [1:0]    head_resp;

   assign ar_idx = araddr[IW+1:2];

`ifdef IMEM_RANGE_CHECK_EN
   logic       q_err_q [QDEPTH];
   logic       ar_err;
   logic [1:0] rresp_q, rresp_d;
   logic       unused_bits;

   assign ar_err      = |araddr[ADDR_W-1:IW+2];
   assign unused_bits = ^araddr[1:0];

   always_ff @(posedge clk) begin
      if (push) q_err_q[wr_ptr_q] <= ar_err;
   end

   always_comb begin
      head_data = mem[q_idx_q[rd_ptr_q]];
      head_resp = 2'b00;
      if (q_err_q[rd_ptr_q]) begin
         head_data = 32'h0000_0013;
         head_resp = 2'b10;
      end
   end

   assign rresp = rresp_q;
`else
   logic unused_bits;

   // High address bits are dropped: the index wraps inside the array.
   assign unused_bits = ^{araddr[ADDR_W-1:IW+2], araddr[1:0]};

   always_comb begin
      head_data = mem[q_idx_q[rd_ptr_q]];
      head_resp = 2'b00;
   end

   assign rresp = 2'b00;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == P_LAST) ? '0 : p + 1'b1;
   endfunction

   // Array and queue payload carry no reset; loads are honoured even in reset.
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
      if (push) q_idx_q[wr_ptr_q] <= ar_idx;
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         lat_q    <= '0;
         rdata_q  <= '0;
`ifdef IMEM_RANGE_CHECK_EN
         rresp_q  <= 2'b00;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         lat_q    <= lat_d;
         rdata_q  <= rdata_d;
`ifdef IMEM_RANGE_CHECK_EN
         rresp_q  <= rresp_d;
`endif
      end
   end

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      rdata_d = rdata_q;
`ifdef IMEM_RANGE_CHECK_EN
      rresp_d = rresp_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (push) begin
               state_d = S_WAIT;
               lat_d   = LAT_INIT;
            end
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               state_d = S_RESP;
               rdata_d = head_data;
`ifdef IMEM_RANGE_CHECK_EN
               rresp_d = head_resp;
`endif
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         S_RESP: begin
            if (rready) begin
               if (count_d != '0) begin
                  state_d = S_WAIT;
                  lat_d   = LAT_INIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      arready = (count_q != Q_FULL) && !rst_q;
      rvalid  = (state_q == S_RESP);
      rdata   = rdata_q;
      push    = arvalid && arready;
      pop     = rvalid && rready;
   end

`ifndef IMEM_RANGE_CHECK_EN
   logic unused_resp;
   assign unused_resp = ^head_resp;
`endif

endmodule
